// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// WIDTH-bit universal shift register with eight operating modes (hold, load,
// logical shift left/right, rotate left/right, arithmetic shift right, clear)
// and a shift counter that pulses `done` once every WIDTH shift/rotate ops.
// This lets the block act as a serializer/deserializer stage.
//
// Parameters:
//   WIDTH      register width in bits (2..32)
//   RESET_VAL  value loaded into Q on reset
//
// Ports:
//   clk     clock; all state updates on posedge
//   rst     synchronous, active-high reset
//   mode    operation select (3 bits, fully decoded)
//   D       parallel load data
//   sin_l   serial in, enters at MSB on logical shift right
//   sin_r   serial in, enters at LSB on logical shift left
//   Q       register contents
//   Q_bar   bitwise complement of Q
//   sout_l  Q[WIDTH-1]
//   sout_r  Q[0]
//   cnt     shift/rotate ops since last load/clear, modulo WIDTH
//   done    registered one-cycle pulse after every WIDTH-th shift/rotate
// -----------------------------------------------------------------------------
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               mode,
  input  logic [WIDTH-1:0]         D,
  input  logic                     sin_l,
  input  logic                     sin_r,
  output logic [WIDTH-1:0]         Q,
  output logic [WIDTH-1:0]         Q_bar,
  output logic                     sout_l,
  output logic                     sout_r,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     done
);

  localparam int          CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_from_lower;  // bit that lands in position gi on a left move
  logic [WIDTH-1:0] w_from_upper;  // bit that lands in position gi on a right move
  logic             w_lsb_fill;
  logic             w_msb_fill;
  logic             w_move_left;
  logic             w_move_right;
  logic             w_is_shift;

  // Fill bits for the ends of the register. Unused serial inputs are muxed
  // out here, so an undriven sin_l/sin_r never reaches Q in other modes.
  always_comb begin
    w_lsb_fill = sin_r;
    if (mode == MODE_ROL) begin
      w_lsb_fill = r_q[WIDTH-1];
    end
  end

  always_comb begin
    w_msb_fill = sin_l;
    case (mode)
      MODE_ROR: w_msb_fill = r_q[0];
      MODE_ASR: w_msb_fill = r_q[WIDTH-1];   // sign extension
      default:  w_msb_fill = sin_l;
    endcase
  end

  assign w_move_left  = (mode == MODE_SHL) || (mode == MODE_ROL);
  assign w_move_right = (mode == MODE_SHR) || (mode == MODE_ROR) || (mode == MODE_ASR);
  assign w_is_shift   = w_move_left || w_move_right;

  // Per-bit neighbour selection; the end bits take the fill values.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign w_from_lower[gi] = w_lsb_fill;
      end else begin : g_lower
        assign w_from_lower[gi] = r_q[gi-1];
      end

      if (gi == WIDTH - 1) begin : g_msb
        assign w_from_upper[gi] = w_msb_fill;
      end else begin : g_upper
        assign w_from_upper[gi] = r_q[gi+1];
      end

      assign w_q_next[gi] = (mode == MODE_LOAD)  ? D[gi]            :
                            (mode == MODE_CLEAR) ? 1'b0             :
                            w_move_left          ? w_from_lower[gi] :
                            w_move_right         ? w_from_upper[gi] :
                                                   r_q[gi];
    end
  endgenerate

  // Data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_next;
    end
  end

  // Shift counter and done pulse. The explicit compare against WIDTH-1 keeps
  // the count modulo WIDTH even when WIDTH is not a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_is_shift) begin
      if (r_cnt == CNT_MAX) begin
        r_cnt  <= '0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_done <= 1'b0;
      end
    end else if (mode == MODE_LOAD || mode == MODE_CLEAR) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      // hold: count is frozen, pulse drops
      r_done <= 1'b0;
    end
  end

  assign Q      = r_q;
  assign Q_bar  = ~r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign cnt    = r_cnt;
  assign done   = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk;
  logic       rst;
  logic [2:0] mode;
  logic [7:0] D;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] Q;
  logic [7:0] Q_bar;
  logic       sout_l;
  logic       sout_r;
  logic [2:0] cnt;
  logic       done;

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .mode(mode), .D(D), .sin_l(sin_l), .sin_r(sin_r),
    .Q(Q), .Q_bar(Q_bar), .sout_l(sout_l), .sout_r(sout_r),
    .cnt(cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [2:0] cnt;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // reference model state
  logic [7:0] m_q    = 8'h00;
  int         m_cnt  = 0;
  logic       m_done = 1'b0;

  // Drive one operation, advance the model and push its expectation,
  // then wait until the DUT has taken the edge.
  task automatic apply(input logic r, input logic [2:0] m, input logic [7:0] d,
                       input logic sl, input logic sr);
    logic [15:0] dbl;
    rst = r; mode = m; D = d; sin_l = sl; sin_r = sr;
    if (r) begin
      m_q = RV; m_cnt = 0; m_done = 1'b0;
    end else begin
      case (m)
        3'd0: m_done = 1'b0;
        3'd1: begin m_q = d;     m_cnt = 0; m_done = 1'b0; end
        3'd7: begin m_q = 8'h00; m_cnt = 0; m_done = 1'b0; end
        default: begin
          dbl = {m_q, m_q};
          case (m)
            3'd2: m_q = (m_q << 1) | {7'd0, sr};
            3'd3: m_q = (m_q >> 1) | {sl, 7'd0};
            3'd4: m_q = dbl[14:7];
            3'd5: m_q = dbl[8:1];
            default: m_q = 8'($signed(m_q) >>> 1);
          endcase
          m_done = (m_cnt == W - 1);
          m_cnt  = (m_cnt + 1) % W;
        end
      endcase
    end
    sb.push_back('{q: m_q, cnt: 3'(m_cnt), done: m_done});
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d rst=%0b mode=%0d D=%h sl=%0b sr=%0b -> Q=%h cnt=%0d done=%0b",
             n_txn, r, m, d, sl, sr, Q, cnt, done);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || Q_bar !== ~e.q || cnt !== e.cnt || done !== e.done) begin
        n_fail++;
        $display("FAIL reset_sb Q=%h Q_bar=%h cnt=%0d done=%0b expected Q=%h cnt=%0d done=%0b",
                 Q, Q_bar, cnt, done, e.q, e.cnt, e.done);
      end
    end
    n_checks++;
    if (Q !== 8'hA5 || Q_bar !== 8'h5A || cnt !== 3'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_value Q=%h Q_bar=%h cnt=%0d done=%0b expected A5 5A 0 0",
               Q, Q_bar, cnt, done);
    end
    apply(1'b0, 3'b000, 8'h00, 1'b1, 1'b1);
    e = sb.pop_front();
    n_checks++;
    if (Q !== 8'hA5 || Q !== e.q || cnt !== e.cnt || done !== e.done) begin
      n_fail++;
      $display("FAIL reset_release_hold Q=%h cnt=%0d done=%0b expected Q=A5 cnt=%0d done=%0b",
               Q, cnt, done, e.cnt, e.done);
    end
  endtask

  task automatic test_shift_left();
    apply(1'b0, 3'b001, 8'h81, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 3'b010, 8'h00, 1'b0, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || sout_l !== e.q[7] || sout_r !== e.q[0] || cnt !== e.cnt || done !== e.done) begin
        n_fail++;
        $display("FAIL shl_step%0d Q=%h cnt=%0d done=%0b expected Q=%h cnt=%0d done=%0b",
                 i, Q, cnt, done, e.q, e.cnt, e.done);
      end
    end
    n_checks++;
    if (Q !== 8'h0F || sout_l !== 1'b0 || cnt !== 3'd3 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL shl_final Q=%h sout_l=%0b cnt=%0d done=%0b expected 0F 0 3 0",
               Q, sout_l, cnt, done);
    end
  endtask

  task automatic test_rotate();
    int pulses = 0;
    apply(1'b0, 3'b001, 8'h96, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 3'b100, 8'hFF, 1'b1, 1'b1);
      e = sb.pop_front();
      if (done === 1'b1) pulses++;
      n_checks++;
      if (Q !== e.q || Q_bar !== ~e.q || cnt !== e.cnt || done !== e.done) begin
        n_fail++;
        $display("FAIL rol_step%0d Q=%h cnt=%0d done=%0b expected Q=%h cnt=%0d done=%0b",
                 i, Q, cnt, done, e.q, e.cnt, e.done);
      end
    end
    n_checks++;
    if (Q !== 8'h96 || done !== 1'b1 || cnt !== 3'd0 || pulses != 1) begin
      n_fail++;
      $display("FAIL rol_full Q=%h done=%0b cnt=%0d pulses=%0d expected 96 1 0 1",
               Q, done, cnt, pulses);
    end
    // rotate right one step, then the pulse must drop
    apply(1'b0, 3'b101, 8'h00, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (Q !== e.q || Q !== 8'h4B || cnt !== 3'd1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ror_step Q=%h cnt=%0d done=%0b expected 4B 1 0", Q, cnt, done);
    end
  endtask

  task automatic test_deserialize();
    logic [7:0] bits = 8'b0100_1101;  // bits[0] fed first
    int pulses = 0;
    apply(1'b0, 3'b111, 8'hFF, 1'b1, 1'b1);
    e = sb.pop_front();
    n_checks++;
    if (Q !== 8'h00 || Q !== e.q || cnt !== 3'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear Q=%h cnt=%0d done=%0b expected 00 0 0", Q, cnt, done);
    end
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 3'b011, 8'hFF, bits[i], 1'b1);
      e = sb.pop_front();
      if (done === 1'b1) pulses++;
      n_checks++;
      if (Q !== e.q || sout_r !== e.q[0] || cnt !== e.cnt || done !== e.done) begin
        n_fail++;
        $display("FAIL shr_step%0d Q=%h cnt=%0d done=%0b expected Q=%h cnt=%0d done=%0b",
                 i, Q, cnt, done, e.q, e.cnt, e.done);
      end
    end
    n_checks++;
    if (Q !== 8'h4D || pulses != 1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL deser_final Q=%h pulses=%0d done=%0b expected 4D 1 1", Q, pulses, done);
    end
  endtask

  task automatic test_arith_shift();
    logic [7:0] ld  [2] = '{8'h90, 8'h70};
    logic [7:0] res [2] = '{8'hE4, 8'h1C};
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 3'b001, ld[k], 1'b0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 2; i++) begin
        apply(1'b0, 3'b110, 8'h00, ~ld[k][7], 1'b1);  // sin_l opposes the sign
        e = sb.pop_front();
        n_checks++;
        if (Q !== e.q || cnt !== e.cnt || done !== e.done) begin
          n_fail++;
          $display("FAIL asr_%0d_step%0d Q=%h cnt=%0d expected Q=%h cnt=%0d",
                   k, i, Q, cnt, e.q, e.cnt);
        end
      end
      n_checks++;
      if (Q !== res[k]) begin
        n_fail++;
        $display("FAIL asr_final%0d Q=%h expected %h", k, Q, res[k]);
      end
    end
  endtask

  task automatic test_interrupt();
    int pulses = 0;
    apply(1'b0, 3'b001, 8'h3C, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 3'b010, 8'h00, 1'b0, 1'(i));
      void'(sb.pop_front());
    end
    apply(1'b1, 3'b010, 8'h00, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++;
    if (Q !== RV || Q !== e.q || cnt !== 3'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset Q=%h cnt=%0d done=%0b expected A5 0 0", Q, cnt, done);
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 4) apply(1'b0, 3'b000, 8'hFF, 1'b1, 1'b1);
      else        apply(1'b0, 3'(2 + (i % 5)), 8'hFF, 1'(i), 1'(~i));
      e = sb.pop_front();
      if (done === 1'b1) pulses++;
      n_checks++;
      if (Q !== e.q || cnt !== e.cnt || done !== e.done) begin
        n_fail++;
        $display("FAIL hold_mix_step%0d Q=%h cnt=%0d done=%0b expected Q=%h cnt=%0d done=%0b",
                 i, Q, cnt, done, e.q, e.cnt, e.done);
      end
      if (i == 4) begin
        n_checks++;
        if (cnt !== 3'd4 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_pause cnt=%0d done=%0b expected 4 0", cnt, done);
        end
      end
    end
    n_checks++;
    if (done !== 1'b1 || pulses != 1 || cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL hold_done done=%0b pulses=%0d cnt=%0d expected 1 1 0", done, pulses, cnt);
    end
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 3'b101, 8'h00, 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    n_checks++;
    if (cnt !== 3'd7 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_load cnt=%0d done=%0b expected 7 0", cnt, done);
    end
    apply(1'b0, 3'b001, 8'hC3, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (Q !== 8'hC3 || Q !== e.q || cnt !== 3'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_at_7 Q=%h cnt=%0d done=%0b expected C3 0 0", Q, cnt, done);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    apply(1'b0, 3'b001, 8'h5A, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 1; i <= 16; i++) begin
      apply(1'b0, 3'(2 + (i % 5)), 8'hFF, 1'(i >> 1), 1'(i));
      e = sb.pop_front();
      if (done === 1'b1) pulses++;
      n_checks++;
      if (Q !== e.q || cnt !== e.cnt || done !== e.done || done !== ((i % 8) == 0)) begin
        n_fail++;
        $display("FAIL b2b_op%0d Q=%h cnt=%0d done=%0b expected Q=%h cnt=%0d done=%0b",
                 i, Q, cnt, done, e.q, e.cnt, e.done);
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL b2b_pulses got=%0d expected 2", pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      apply(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), 1'($urandom));
      e = sb.pop_front();
      n_checks++;
      if (Q !== e.q || Q_bar !== ~e.q || sout_l !== e.q[7] || sout_r !== e.q[0] ||
          cnt !== e.cnt || done !== e.done) begin
        n_fail++;
        $display("FAIL random%0d Q=%h cnt=%0d done=%0b expected Q=%h cnt=%0d done=%0b",
                 i, Q, cnt, done, e.q, e.cnt, e.done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 3'b000; D = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    #1;
    test_reset();
    test_shift_left();
    test_rotate();
    test_deserialize();
    test_arith_shift();
    test_interrupt();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
